// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller: opcodes, func fields,
// ALU/WHB codes and the sequencer state type.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_X3  = 3'b011;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SLL = 4'b1010;

    localparam logic [1:0] WHB_BYTE = 2'b00;
    localparam logic [1:0] WHB_HALF = 2'b01;
    localparam logic [1:0] WHB_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    // ALU code for the shared R/I-type func3 field; SUB is selected separately by func7.
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3);
        case (f3)
            F3_SLL:  return ALU_SLL;
            F3_XOR:  return ALU_XOR;
            F3_SRL:  return ALU_SRL;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv_instr_decoder.sv
// Combinational instruction decoder: IR -> legality, ALU control and memory attributes.
module rv_instr_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output logic        legal,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic        is_load,
    output logic        is_store,
    output logic [1:0]  whb
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f3_alu_ok;
    logic       f3_mem_ok;
    logic       unused_fields;

    assign opcode        = ir[6:0];
    assign f3            = ir[14:12];
    assign f7            = ir[31:25];
    assign unused_fields = ^{ir[24:15], ir[11:7]};

    assign f3_alu_ok = (f3 != F3_W) && (f3 != F3_X3);
    assign f3_mem_ok = (f3 == F3_ADD) || (f3 == F3_SLL) || (f3 == F3_W);

    always_comb begin
        legal      = 1'b0;
        alu_ctrl   = ALU_ADD;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        whb        = WHB_BYTE;
        case (opcode)
            OP_RTYPE: begin
                if (f7 == F7_ZERO && f3_alu_ok) begin
                    legal    = 1'b1;
                    alu_ctrl = f3_to_alu(f3);
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    legal    = 1'b1;
                    alu_ctrl = ALU_SUB;
                end
            end
            OP_ITYPE: begin
                // Shift-immediates carry func7 in the upper immediate bits; only the logical forms decode.
                if (f3_alu_ok && ((f3 != F3_SLL && f3 != F3_SRL) || f7 == F7_ZERO)) begin
                    legal    = 1'b1;
                    alu_src  = 1'b1;
                    alu_ctrl = f3_to_alu(f3);
                end
            end
            OP_LOAD: begin
                if (f3_mem_ok) begin
                    legal      = 1'b1;
                    alu_src    = 1'b1;
                    mem_to_reg = 1'b1;
                    is_load    = 1'b1;
                    whb        = f3[1:0];
                end
            end
            OP_STORE: begin
                if (f3_mem_ok) begin
                    legal    = 1'b1;
                    alu_src  = 1'b1;
                    is_store = 1'b1;
                    whb      = f3[1:0];
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencer: fetch/decode/exec/mem/writeback phases, wait timeout,
// retired-instruction counter and sticky halt flags.
module multicycle_ctrl_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic             ir_en,
    output logic [3:0]       alu_ctrl,
    output logic             alu_src,
    output logic             mem_to_reg,
    output logic             dmem_req,
    output logic             dmem_rw,
    output logic [1:0]       dmem_whb,
    input  logic             dmem_ready,
    output logic             rf_we,
    output logic             pc_en,
    output logic [CNT_W-1:0] instret,
    output logic             halted,
    output logic             illegal,
    output logic             timeout
);

    localparam int unsigned WCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

    state_e         state, next_state;
    logic [31:0]    ir;
    logic [WCW-1:0] wait_cnt;
    logic           is_load_q, is_store_q;

    logic           dec_legal, dec_alu_src, dec_mem_to_reg, dec_is_load, dec_is_store;
    logic [3:0]     dec_alu_ctrl;
    logic [1:0]     dec_whb;

    logic           dec_capture, set_illegal, set_timeout, wait_inc, wait_hit;

    rv_instr_decoder u_dec (
        .ir         (ir),
        .legal      (dec_legal),
        .alu_ctrl   (dec_alu_ctrl),
        .alu_src    (dec_alu_src),
        .mem_to_reg (dec_mem_to_reg),
        .is_load    (dec_is_load),
        .is_store   (dec_is_store),
        .whb        (dec_whb)
    );

    assign wait_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == WAIT_LAST);
    assign halted   = (state == ST_HALT);

    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        ir_en       = 1'b0;
        rf_we       = 1'b0;
        pc_en       = 1'b0;
        dec_capture = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        wait_inc    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_en) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                // Ready takes priority over the timeout in the cycle the limit is reached.
                if (imem_ready) begin
                    ir_en      = 1'b1;
                    next_state = ST_DECODE;
                end else if (wait_hit) begin
                    set_timeout = 1'b1;
                    next_state  = ST_HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    dec_capture = 1'b1;
                    next_state  = ST_EXEC;
                end else begin
                    set_illegal = 1'b1;
                    next_state  = ST_HALT;
                end
            end
            ST_EXEC: begin
                next_state = (is_load_q || is_store_q) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    if (is_store_q) begin
                        pc_en      = 1'b1;
                        next_state = ST_IDLE;
                    end else begin
                        next_state = ST_WB;
                    end
                end else if (wait_hit) begin
                    set_timeout = 1'b1;
                    next_state  = ST_HALT;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ST_WB: begin
                rf_we      = 1'b1;
                pc_en      = 1'b1;
                next_state = ST_IDLE;
            end
            ST_HALT: ;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ir         <= '0;
            wait_cnt   <= '0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            alu_ctrl   <= '0;
            alu_src    <= 1'b0;
            mem_to_reg <= 1'b0;
            dmem_rw    <= 1'b0;
            dmem_whb   <= '0;
            instret    <= '0;
            illegal    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
            if (ir_en) ir <= imem_rdata;
            if (dec_capture) begin
                is_load_q  <= dec_is_load;
                is_store_q <= dec_is_store;
                alu_ctrl   <= dec_alu_ctrl;
                alu_src    <= dec_alu_src;
                mem_to_reg <= dec_mem_to_reg;
                dmem_rw    <= dec_is_load;
                dmem_whb   <= dec_whb;
            end
            if (pc_en)       instret <= instret + 1'b1;
            if (set_illegal) illegal <= 1'b1;
            if (set_timeout) timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed instructions push expected retire/halt
// events; a negedge monitor pops and compares when the DUT retires or halts.
module tb_multicycle_ctrl_fsm;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst, run_en, imem_ready, dmem_ready;
    logic [31:0]   imem_rdata;
    logic          imem_req, ir_en, alu_src, mem_to_reg, dmem_req, dmem_rw;
    logic          rf_we, pc_en, halted, illegal, timeout;
    logic [3:0]    alu_ctrl;
    logic [1:0]    dmem_whb;
    logic [CW-1:0] instret;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run_en(run_en),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .ir_en(ir_en), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .dmem_req(dmem_req), .dmem_rw(dmem_rw), .dmem_whb(dmem_whb), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .pc_en(pc_en), .instret(instret),
        .halted(halted), .illegal(illegal), .timeout(timeout)
    );

    typedef struct {
        int            kind;   // 0 = retire, 1 = halt
        int            lat;
        int            dcyc;
        int            rfwe;
        logic [3:0]    alu;
        logic          src, m2r, rw;
        logic [1:0]    whb;
        logic [CW-1:0] cnt;
        logic          ill, tmo;
        int            fcyc;
    } exp_t;

    exp_t          sbq[$];
    int            total = 0;
    int            bad = 0;
    logic [CW-1:0] exp_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitor
    int   cyc = 0, t_ir = 0, dcnt = 0, rcnt = 0, frun = 0;
    logic prev_req = 1'b0, prev_halt = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            prev_req  = 1'b0;
            prev_halt = 1'b0;
        end else begin
            cyc++;
            if (imem_req && !prev_req) frun = 0;
            if (imem_req) frun++;
            prev_req = imem_req;
            if (ir_en) begin
                t_ir = cyc; dcnt = 0; rcnt = 0;
            end
            if (dmem_req) dcnt++;
            if (rf_we) rcnt++;
            if (pc_en) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_retire got=pc_en exp=none");
                end else begin
                    e = sbq.pop_front();
                    chk("retire_kind", 0, e.kind);
                    chk("latency", cyc - t_ir, e.lat);
                    chk("dmem_req_cycles", dcnt, e.dcyc);
                    chk("rf_we_cycles", rcnt, e.rfwe);
                    chk("alu_ctrl", alu_ctrl, e.alu);
                    chk("alu_src", alu_src, e.src);
                    chk("mem_to_reg", mem_to_reg, e.m2r);
                    chk("dmem_rw", dmem_rw, e.rw);
                    chk("dmem_whb", dmem_whb, e.whb);
                    chk("instret", instret, e.cnt);
                end
            end
            if (halted && !prev_halt) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_halt got=halted exp=none");
                end else begin
                    e = sbq.pop_front();
                    chk("halt_kind", 1, e.kind);
                    chk("illegal_flag", illegal, e.ill);
                    chk("timeout_flag", timeout, e.tmo);
                    chk("fetch_req_cycles", frun, e.fcyc);
                    chk("halt_req_dropped", imem_req | dmem_req | rf_we | pc_en, 0);
                    if (e.ill) begin
                        chk("illegal_halt_lat", cyc - t_ir, 2);
                        chk("illegal_no_rfwe", rcnt, 0);
                    end
                end
            end
            prev_halt = halted;
        end
    end

    // Stimulus helpers
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_sig(input int which, input string name);
        logic s;
        for (int i = 0; i < 40; i++) begin
            s = (which == 0) ? imem_req : (which == 1) ? dmem_req : halted;
            if (s) break;
            step();
        end
        s = (which == 0) ? imem_req : (which == 1) ? dmem_req : halted;
        chk(name, s, 1);
    endtask

    task automatic push_ret(input logic [3:0] alu, input logic src, input logic m2r, input logic rw,
                            input logic [1:0] whb, input int lat, input int dcyc, input int rfwe);
        exp_t e;
        e = '{kind: 0, lat: lat, dcyc: dcyc, rfwe: rfwe, alu: alu, src: src, m2r: m2r, rw: rw,
              whb: whb, cnt: exp_cnt, ill: 1'b0, tmo: 1'b0, fcyc: 0};
        exp_cnt = exp_cnt + 1'b1;
        sbq.push_back(e);
    endtask

    task automatic push_halt(input logic ill, input logic tmo, input int fcyc);
        exp_t e;
        e = '{kind: 1, lat: 0, dcyc: 0, rfwe: 0, alu: 4'h0, src: 1'b0, m2r: 1'b0, rw: 1'b0,
              whb: 2'b00, cnt: '0, ill: ill, tmo: tmo, fcyc: fcyc};
        sbq.push_back(e);
    endtask

    task automatic fetch(input logic [31:0] ins, input int d);
        wait_sig(0, "imem_req_seen");
        repeat (d) step();
        imem_rdata = ins;
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
    endtask

    task automatic dmem(input int d);
        wait_sig(1, "dmem_req_seen");
        repeat (d) step();
        dmem_ready = 1'b1;
        step();
        dmem_ready = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] ins, input logic [3:0] alu, input logic src, input int di);
        push_ret(alu, src, 1'b0, 1'b0, 2'b00, 3, 0, 1);
        fetch(ins, di);
    endtask

    task automatic load_op(input logic [31:0] ins, input logic [1:0] whb, input int d);
        push_ret(4'b0000, 1'b1, 1'b1, 1'b1, whb, 4 + d, d + 1, 1);
        fetch(ins, 0);
        dmem(d);
    endtask

    task automatic store_op(input logic [31:0] ins, input logic [1:0] whb, input int d);
        push_ret(4'b0000, 1'b1, 1'b0, 1'b0, whb, 3 + d, d + 1, 0);
        fetch(ins, 0);
        dmem(d);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (sbq.size() == 0) break;
            step();
        end
        chk(name, sbq.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; run_en = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        exp_cnt = '0;
        chk("rst_halted", halted, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_instret", instret, 0);
        chk("rst_strobes", {imem_req, dmem_req, ir_en, rf_we, pc_en}, 0);
    endtask

    initial begin : stim
        int n;
        rst = 1'b1; run_en = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
        exp_cnt = '0;
        step(); step();
        chk("reset_alu_ctrl", alu_ctrl, 0);
        chk("reset_dmem", {alu_src, mem_to_reg, dmem_rw, dmem_whb}, 0);
        do_reset();

        run_en = 1'b1;
        alu_op(32'h002081B3, 4'b0000, 1'b0, 0);      // ADD
        load_op(32'h00802283, 2'b10, 3);             // LW
        store_op(32'h00502623, 2'b10, 0);            // SW
        alu_op(32'h40208233, 4'b0001, 1'b0, 0);      // SUB
        alu_op(32'h0070C293, 4'b1000, 1'b1, 2);      // XORI
        alu_op(32'h0030D313, 4'b1001, 1'b1, 0);      // SRLI
        load_op(32'h00008383, 2'b00, 1);             // LB
        store_op(32'h00509123, 2'b01, 2);            // SH
        alu_op(32'h002081B3, 4'b0000, 1'b0, 3);      // ADD, ready on the limit cycle
        alu_op(32'h002081B3, 4'b0000, 1'b0, 0);
        run_en = 1'b0;
        drain("drain_first");

        // Parked in IDLE: stray readies must be ignored.
        imem_ready = 1'b1; dmem_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req || dmem_req || ir_en || pc_en) n++;
        end
        imem_ready = 1'b0; dmem_ready = 1'b0;
        chk("park_activity", n, 0);
        chk("park_instret", instret, exp_cnt);

        run_en = 1'b1;
        for (int i = 0; i < 7; i++) alu_op(32'h002081B3, 4'b0000, 1'b0, 0);
        run_en = 1'b0;
        drain("drain_wrap");
        chk("instret_wrapped", instret, 4'd1);
        chk("not_halted", halted, 0);

        // Illegal instructions
        do_reset();
        run_en = 1'b1;
        push_halt(1'b1, 1'b0, 1);
        fetch(32'hFFFFFFFF, 0);
        wait_sig(2, "halt_seen_ffff");
        repeat (3) step();
        chk("illegal_sticky", {halted, illegal, timeout}, 3'b110);
        chk("illegal_instret", instret, 0);
        do_reset();
        run_en = 1'b1;
        push_halt(1'b1, 1'b0, 1);
        fetch(32'h4030D313, 0);                      // SRAI form is outside the subset
        wait_sig(2, "halt_seen_srai");
        run_en = 1'b0;
        step();

        // Fetch timeout
        do_reset();
        run_en = 1'b1;
        push_halt(1'b0, 1'b1, TO);
        wait_sig(2, "halt_seen_timeout");
        run_en = 1'b0;
        repeat (3) step();
        chk("timeout_req_low", imem_req, 0);
        chk("timeout_sticky", {halted, illegal, timeout}, 3'b101);
        do_reset();
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
